ldpc_row_accumulator: RTL and testbench
=======================================

LDPC_ROW_ACCUMULATOR -- requirements
Module: ldpc_row_accumulator

Interface
REQ-001 SHALL have parameter Z, default 54, meaning circulant size in bits.
REQ-002 SHALL have parameter NUM_INFO_BLKS, default 20, meaning information columns per codeword.
REQ-003 SHALL have parameter NUM_PARITY_BLKS, default 4, meaning proto-matrix rows (parity blocks).
REQ-004 SHALL have parameter TOTAL_BLKS, default NUM_INFO_BLKS+NUM_PARITY_BLKS, meaning proto-matrix columns.
REQ-005 SHALL have parameter ENTRY_W, default 8, meaning proto-matrix entry width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1 bit: single-cycle frame start.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port in_valid, input, 1 bit: in_data holds a valid information block.
REQ-012 SHALL have port in_ready, output, 1 bit: block accepted when in_valid and in_ready are both high.
REQ-013 SHALL have port in_data, input, Z bits: information block, bit 0 first.
REQ-014 SHALL have port rom_addr, output, $clog2(NUM_PARITY_BLKS*TOTAL_BLKS) bits: proto-matrix ROM address.
REQ-015 SHALL have port rom_data, input, ENTRY_W bits: asynchronous ROM read data, valid in the same cycle as rom_addr.
REQ-016 SHALL have port out_valid, output, 1 bit: accumulators are final.
REQ-017 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-018 SHALL have port out_data, output, NUM_PARITY_BLKS*Z bits: row accumulators, row r in bits [r*Z +: Z].
REQ-019 SHALL have port err, output, 1 bit: sticky flag for an illegal ROM entry in the current frame.

Function
REQ-020 SHALL implement states IDLE, LOAD, ACC and OUT.
REQ-021 SHALL, in IDLE, on start, clear all accumulators and err, set col=0, and go to LOAD.
REQ-022 SHALL ignore start in every state other than IDLE.
REQ-023 SHALL drive in_ready=1 only in LOAD; on handshake, register in_data, set row=0, and go to ACC.
REQ-024 SHALL, in ACC, process one row per cycle for rows 0..NUM_PARITY_BLKS-1, driving rom_addr = row*TOTAL_BLKS + col.
REQ-025 SHALL treat entry 0xFF (NULL_SHIFT) as a zero circulant: no XOR.
REQ-026 SHALL, for an entry s < Z, update acc[row][j] ^= blk[(j+s) mod Z] for every j in 0..Z-1.
REQ-027 SHALL, for an entry s >= Z other than 0xFF, set err=1 and perform no XOR.
REQ-028 SHALL, after the last row, return to LOAD with col+1 if col < NUM_INFO_BLKS-1; otherwise go to OUT.
REQ-029 SHALL hold out_valid=1 and out_data stable in OUT until out_ready; on that handshake, go to IDLE with out_valid=0 the next cycle.
REQ-030 SHALL meet these timings: 1+NUM_PARITY_BLKS cycles per block with in_valid held high; out_valid rises the cycle after the last ACC cycle (column 19, row 3).
REQ-031 SHALL drive rom_addr=0 outside ACC.
REQ-032 SHALL keep err valid through OUT and clear it only on the next accepted start.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state=IDLE, busy=0, in_ready=0, out_valid=0, err=0, out_data=0, col=0 and row=0.
REQ-034 SHALL, on reset mid-frame, discard the partial frame; the first action after reset is a start in IDLE.

Structure
REQ-035 SHALL place Z, NUM_INFO_BLKS, NUM_PARITY_BLKS, TOTAL_BLKS, ENTRY_W, NULL_SHIFT (8'hFF) and the state enum in shared package ldpc_pkg.
REQ-036 SHALL implement rotation in combinational sub-module circ_shift (Z-bit data, shift input, out[j]=in[(j+s) mod Z]).
REQ-037 SHALL use a single shared circ_shift instance feeding the addressed row accumulator.

Verification
REQ-038 SHALL cover: all ROM entries 0xFF, 20 random blocks -> out_data all zero, err=0.
REQ-039 SHALL cover: entry(0,0)=0, others null, block0=1 (bit 0), others zero -> out_data bit 0 = 1 only.
REQ-040 SHALL cover: entry(2,5)=1, others null, block5 bit 0 set -> out_data bit 2*54+53 = 1 only.
REQ-041 SHALL cover: entry(1,3)=60 -> err=1 at out_valid, row-1 contribution from column 3 absent.
REQ-042 SHALL cover: in_valid=1 continuously, out_ready held 0 for 10 cycles -> out_data stable, out_valid high; start pulses ignored; frame takes 100 cycles from first handshake.
REQ-043 SHALL cover: rst_n low during column 7 ACC, then a new frame -> outputs zero during reset, and the second frame result equals the golden model.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants and FSM state type for the LDPC row accumulator.
package ldpc_pkg;

    localparam int unsigned Z               = 54;
    localparam int unsigned NUM_INFO_BLKS   = 20;
    localparam int unsigned NUM_PARITY_BLKS = 4;
    localparam int unsigned TOTAL_BLKS      = NUM_INFO_BLKS + NUM_PARITY_BLKS;
    localparam int unsigned ENTRY_W         = 8;

    // Proto-matrix entry meaning "zero circulant".
    localparam logic [7:0]  NULL_SHIFT      = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StAcc,
        StOut
    } state_t;

endpackage

// File: rtl/circ_shift.sv
// Combinational cyclic rotation: dout[j] = din[(j + shift) mod DATA_W].
// Result is only meaningful for shift < DATA_W; callers filter larger values.
module circ_shift #(
    parameter int unsigned DATA_W  = ldpc_pkg::Z,
    parameter int unsigned SHIFT_W = ldpc_pkg::ENTRY_W
) (
    input  logic [DATA_W-1:0]  din,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  dout
);

    logic [2*DATA_W-1:0] dbl;

    // Doubling the word turns the modular rotation into a plain right shift.
    always_comb begin
        dbl  = {din, din};
        dout = DATA_W'(dbl >> shift);
    end

endmodule

// File: rtl/ldpc_row_accumulator.sv
// Accumulates rotated information blocks into per-row parity accumulators,
// one proto-matrix row per cycle, using a single shared rotator.
module ldpc_row_accumulator #(
    parameter int unsigned Z               = ldpc_pkg::Z,
    parameter int unsigned NUM_INFO_BLKS   = ldpc_pkg::NUM_INFO_BLKS,
    parameter int unsigned NUM_PARITY_BLKS = ldpc_pkg::NUM_PARITY_BLKS,
    parameter int unsigned TOTAL_BLKS      = NUM_INFO_BLKS + NUM_PARITY_BLKS,
    parameter int unsigned ENTRY_W         = ldpc_pkg::ENTRY_W
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    output logic                                        busy,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [Z-1:0]                                in_data,
    output logic [$clog2(NUM_PARITY_BLKS*TOTAL_BLKS)-1:0] rom_addr,
    input  logic [ENTRY_W-1:0]                          rom_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [NUM_PARITY_BLKS*Z-1:0]                out_data,
    output logic                                        err
);

    import ldpc_pkg::*;

    localparam int unsigned AW = $clog2(NUM_PARITY_BLKS * TOTAL_BLKS);
    localparam int unsigned CW = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1;
    localparam int unsigned RW = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     col_q, col_d;
    logic [RW-1:0]                     row_q, row_d;
    logic [Z-1:0]                      blk_q, blk_d;
    logic [NUM_PARITY_BLKS-1:0][Z-1:0] acc_q, acc_d;
    logic                              err_q, err_d;

    logic [Z-1:0] rot;
    logic         entry_null;
    logic         entry_ok;
    logic         last_row;
    logic         last_col;

    circ_shift #(
        .DATA_W  (Z),
        .SHIFT_W (ENTRY_W)
    ) u_circ_shift (
        .din   (blk_q),
        .shift (rom_data),
        .dout  (rot)
    );

    assign entry_null = (rom_data == ENTRY_W'(NULL_SHIFT));
    assign entry_ok   = (32'(rom_data) < Z);
    assign last_row   = (row_q == RW'(NUM_PARITY_BLKS - 1));
    assign last_col   = (col_q == CW'(NUM_INFO_BLKS - 1));

    // Next-state logic: frame sequencing and accumulator update.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        blk_d   = blk_q;
        acc_d   = acc_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    err_d   = 1'b0;
                    col_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    blk_d   = in_data;
                    row_d   = '0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (!entry_null) begin
                    if (entry_ok) begin
                        acc_d[row_q] = acc_q[row_q] ^ rot;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (last_row) begin
                    row_d = '0;
                    if (last_col) begin
                        state_d = StOut;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = StLoad;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset discarding any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            blk_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            blk_q   <= blk_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy      = (state_q != StIdle);
        in_ready  = (state_q == StLoad);
        out_valid = (state_q == StOut);
        err       = err_q;
        out_data  = acc_q;
        rom_addr  = '0;
        if (state_q == StAcc) begin
            rom_addr = AW'(row_q * TOTAL_BLKS + col_q);
        end
    end

endmodule

// File: tb/tb_ldpc_row_accumulator.sv
// Directed bench for ldpc_row_accumulator: vector table plus frame-level sequences.
module tb_ldpc_row_accumulator;

    localparam int Z  = 54;
    localparam int NI = 20;
    localparam int NP = 4;
    localparam int TB = 24;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [Z-1:0]  in_data = '0;
    logic          busy;
    logic          in_ready;
    logic          out_valid;
    logic          err;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [NP*Z-1:0] out_data;

    logic [7:0]   rom [0:127];
    logic [Z-1:0] blk [0:NI-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int r;
        int c;
        int s;
        int bc;
        int bb;
        int eb;
        bit ee;
    } vec_t;

    vec_t vecs [0:7];

    ldpc_row_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 8'hFF;
    endtask

    task automatic golden(output logic [NP*Z-1:0] d, output logic e);
        int s;
        d = '0;
        e = 1'b0;
        for (int r = 0; r < NP; r++) begin
            for (int c = 0; c < NI; c++) begin
                s = int'(rom[r*TB + c]);
                if (s == 255) continue;
                if (s >= Z) begin
                    e = 1'b1;
                    continue;
                end
                for (int j = 0; j < Z; j++) begin
                    d[r*Z + j] = d[r*Z + j] ^ blk[c][(j + s) % Z];
                end
            end
        end
    endtask

    // Starts a frame and feeds all blocks with in_valid held high. Returns at the
    // negedge where out_valid is first seen (lat = cycles since first handshake),
    // or right after column abort_col has entered ACC when abort_col >= 0.
    task automatic run_frame(input int abort_col, input bit start_noise,
                             output int lat, output bit aborted);
        int  idx;
        int  t0;
        bit  hs;
        bit  abort_pending;
        idx = 0;
        t0 = -1;
        lat = -1;
        aborted = 1'b0;
        abort_pending = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int guard = 0; guard < 400; guard++) begin
            if (abort_pending) begin
                in_valid = 1'b0;
                start = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (out_valid) begin
                lat = cyc - t0;
                break;
            end
            in_valid = (idx < NI);
            in_data = (idx < NI) ? blk[idx] : '0;
            start = start_noise && (idx >= 10) && (idx < 12);
            hs = in_ready && in_valid;
            if (hs && t0 < 0) t0 = cyc;
            if (hs) begin
                idx++;
                if (abort_col >= 0 && idx == abort_col + 1) abort_pending = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (lat < 0 && abort_col < 0) begin
            failures++;
            checks++;
            $display("FAIL frame_timeout got=no_out_valid exp=out_valid");
        end
    endtask

    task automatic finish_out(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_ov_drop"}, out_valid, 1'b0);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_in_ready"}, in_ready, 1'b0);
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_err"}, err, 1'b0);
        check({name, "_out_data"}, out_data, '0);
        check({name, "_rom_addr"}, rom_addr, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NP*Z-1:0] gd;
        logic            ge;
        logic [NP*Z-1:0] exp_d;
        int              lat;
        bit              ab;

        vecs[0] = '{r: 0, c: 0,  s: 0,   bc: 0,  bb: 0,  eb: 0,   ee: 1'b0};
        vecs[1] = '{r: 2, c: 5,  s: 1,   bc: 5,  bb: 0,  eb: 161, ee: 1'b0};
        vecs[2] = '{r: 1, c: 3,  s: 60,  bc: 3,  bb: 0,  eb: -1,  ee: 1'b1};
        vecs[3] = '{r: 3, c: 19, s: 10,  bc: 19, bb: 10, eb: 162, ee: 1'b0};
        vecs[4] = '{r: 1, c: 7,  s: 53,  bc: 7,  bb: 0,  eb: 55,  ee: 1'b0};
        vecs[5] = '{r: 0, c: 2,  s: 255, bc: 2,  bb: 5,  eb: -1,  ee: 1'b0};
        vecs[6] = '{r: 2, c: 0,  s: 54,  bc: 0,  bb: 0,  eb: -1,  ee: 1'b1};
        vecs[7] = '{r: 1, c: 1,  s: 20,  bc: 1,  bb: 19, eb: 107, ee: 1'b0};

        clear_rom();
        for (int i = 0; i < NI; i++) blk[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single-entry proto matrices with hand-computed results.
        for (int v = 0; v < 8; v++) begin
            clear_rom();
            rom[vecs[v].r*TB + vecs[v].c] = 8'(vecs[v].s);
            for (int i = 0; i < NI; i++) blk[i] = '0;
            blk[vecs[v].bc][vecs[v].bb] = 1'b1;
            exp_d = '0;
            if (vecs[v].eb >= 0) exp_d[vecs[v].eb] = 1'b1;
            run_frame(-1, 1'b0, lat, ab);
            check($sformatf("vec%0d_data", v), out_data, exp_d);
            check($sformatf("vec%0d_err", v), err, vecs[v].ee);
            check($sformatf("vec%0d_lat", v), lat, 100);
            finish_out($sformatf("vec%0d", v));
        end

        // All-null matrix with random blocks.
        clear_rom();
        for (int i = 0; i < NI; i++) blk[i] = Z'({$urandom(), $urandom()});
        run_frame(-1, 1'b0, lat, ab);
        check("null_data", out_data, '0);
        check("null_err", err, 1'b0);
        check("null_lat", lat, 100);
        finish_out("null");

        // Random matrix, start noise mid-frame, output back-pressure with start pulses.
        clear_rom();
        for (int i = 0; i < NP*TB; i++) begin
            rom[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, Z-1));
        end
        for (int i = 0; i < NI; i++) blk[i] = Z'({$urandom(), $urandom()});
        golden(gd, ge);
        run_frame(-1, 1'b1, lat, ab);
        check("bp_lat", lat, 100);
        check("bp_data", out_data, gd);
        check("bp_err", err, ge);
        for (int k = 0; k < 10; k++) begin
            start = (k >= 3 && k < 6);
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", k), out_valid, 1'b1);
            check($sformatf("bp_hold%0d_data", k), out_data, gd);
        end
        start = 1'b0;
        check("bp_hold_err", err, ge);
        finish_out("bp");

        // Reset during column 7 accumulation, then a clean frame.
        clear_rom();
        for (int i = 0; i < NP*TB; i++) begin
            case ($urandom_range(0, 7))
                0:       rom[i] = 8'hFF;
                1:       rom[i] = 8'($urandom_range(Z, 254));
                default: rom[i] = 8'($urandom_range(0, Z-1));
            endcase
        end
        for (int i = 0; i < NI; i++) blk[i] = Z'({$urandom(), $urandom()});
        run_frame(7, 1'b0, lat, ab);
        check("abort_reached", ab, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) blk[i] = Z'({$urandom(), $urandom()});
        golden(gd, ge);
        run_frame(-1, 1'b0, lat, ab);
        check("post_reset_data", out_data, gd);
        check("post_reset_err", err, ge);
        check("post_reset_lat", lat, 100);
        finish_out("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
